// File: rtl/stage_fetch_pkg.sv
// Shared definitions for the fetch stage: the NOP encoding, the F/D register
// state codes and a small helper used to decide when the F/D word is real.
package stage_fetch_pkg;

  // All-zero word is the nop the decoder expects when nothing valid is in F/D.
  localparam logic [31:0] NOP_INSN = 32'd0;

  // State of the F/D register. Code 2'd3 is unused; the fetch logic handles it
  // exactly like BUBBLE so a corrupted state can never present a fake insn.
  typedef enum logic [1:0] {
    ST_BUBBLE = 2'd0,
    ST_LIVE   = 2'd1,
    ST_HELD   = 2'd2
  } fetch_state_e;

  // True when the F/D register carries a real instruction for decode.
  function automatic logic fd_is_valid(input fetch_state_e st);
    return (st == ST_LIVE) || (st == ST_HELD);
  endfunction

endpackage : stage_fetch_pkg

// File: rtl/stage_fetch_if.sv
// Bundle of everything the fetch stage exchanges with the rest of the core:
// hazard/redirect control in, the instruction RAM port, and the F/D outputs.
// The master modport is the fetch stage's view; slave is its environment.
interface stage_fetch_if #(
  parameter int ADDR_W = 12
) ();

  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_q;
  logic [31:0]       fd_insn;
  logic              fd_valid;
  logic [31:0]       fd_pc_plus_4;
  logic [4:0]        fd_pc_upper_5;
  logic              flush_dx;
  logic [31:0]       pc_out;

  modport master (
    input  stall,
    input  redirect,
    input  redirect_pc,
    input  imem_q,
    output imem_addr,
    output fd_insn,
    output fd_valid,
    output fd_pc_plus_4,
    output fd_pc_upper_5,
    output flush_dx,
    output pc_out
  );

  modport slave (
    output stall,
    output redirect,
    output redirect_pc,
    output imem_q,
    input  imem_addr,
    input  fd_insn,
    input  fd_valid,
    input  fd_pc_plus_4,
    input  fd_pc_upper_5,
    input  flush_dx,
    input  pc_out
  );

endinterface : stage_fetch_if

// File: rtl/stage_fetch_pc_reg.sv
// 32-bit load-enable register with asynchronous active-high reset to a
// parameterised value. Used for the PC, the F/D PC and the stall hold word.
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Load d when enabled, otherwise keep the stored value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pc_reg

// File: rtl/stage_fetch.sv
// Fetch stage: owns the PC, addresses the synchronous instruction RAM, holds
// the F/D pipeline register and squashes wrong-path words on a redirect.
// A stall captures the RAM word into hold_q so it survives while the PC is
// frozen; the RAM simply re-reads the same address during the stall.
module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          ADDR_W   = 12
) (
  input  logic          clock,
  input  logic          reset,
  stage_fetch_if.master fif
);

  fetch_state_e st_q;
  fetch_state_e st_d;

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        pc_en;

  logic [31:0] fd_pc;
  logic        fd_pc_en;

  logic [31:0] hold_q;
  logic        hold_en;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc_reg (
    .clock (clock),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  // F/D PC only ever loads the PC that is being handed to decode.
  pc_reg #(.RESET_VAL(32'd0)) u_fd_pc_reg (
    .clock (clock),
    .reset (reset),
    .en    (fd_pc_en),
    .d     (pc_q),
    .q     (fd_pc)
  );

  // Hold word captures the RAM output on the edge a stall starts.
  pc_reg #(.RESET_VAL(32'd0)) u_hold_reg (
    .clock (clock),
    .reset (reset),
    .en    (hold_en),
    .d     (fif.imem_q),
    .q     (hold_q)
  );

  // F/D state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q <= ST_BUBBLE;
    end else begin
      st_q <= st_d;
    end
  end

  // Next state and register enables; redirect beats stall beats advance.
  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q + 32'd1;
    pc_en    = 1'b0;
    fd_pc_en = 1'b0;
    hold_en  = 1'b0;

    if (fif.redirect) begin
      st_d  = ST_BUBBLE;
      pc_d  = fif.redirect_pc;
      pc_en = 1'b1;
    end else begin
      case (st_q)
        ST_LIVE: begin
          if (fif.stall) begin
            st_d    = ST_HELD;
            hold_en = 1'b1;
          end else begin
            st_d     = ST_LIVE;
            pc_en    = 1'b1;
            fd_pc_en = 1'b1;
          end
        end
        ST_HELD: begin
          if (!fif.stall) begin
            st_d     = ST_LIVE;
            pc_en    = 1'b1;
            fd_pc_en = 1'b1;
          end
        end
        default: begin
          if (fif.stall) begin
            st_d = ST_BUBBLE;
          end else begin
            st_d     = ST_LIVE;
            pc_en    = 1'b1;
            fd_pc_en = 1'b1;
          end
        end
      endcase
    end
  end

  // F/D outputs; anything that is not LIVE or HELD shows a nop so an X from
  // the RAM during a bubble never reaches decode.
  always_comb begin
    fif.fd_insn = NOP_INSN;
    case (st_q)
      ST_LIVE: fif.fd_insn = fif.imem_q;
      ST_HELD: fif.fd_insn = hold_q;
      default: fif.fd_insn = NOP_INSN;
    endcase
    fif.fd_valid      = fd_is_valid(st_q);
    fif.fd_pc_plus_4  = fd_pc + 32'd1;
    fif.fd_pc_upper_5 = fd_pc[31:27];
    fif.flush_dx      = fif.redirect;
    fif.pc_out        = pc_q;
    fif.imem_addr     = pc_q[ADDR_W-1:0];
  end

endmodule : stage_fetch

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: a behavioural RAM returning addr+100, and a
// scoreboard of expected F/D contents pushed with each stimulus cycle and
// popped on the following falling edge.
module tb_stage_fetch;

  localparam int ADDR_W = 12;

  typedef struct {
    string       tag;
    logic        valid;
    logic [31:0] insn;
    logic [31:0] fd_pc;
    logic [31:0] pc;
  } exp_t;

  logic clock;
  logic reset;
  int   assert_count;
  int   fail_count;
  exp_t sb_queue[$];

  stage_fetch_if #(.ADDR_W(ADDR_W)) fif ();

  stage_fetch #(.RESET_PC(32'd0), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .fif   (fif.master)
  );

  // 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM model: mem[k] = k + 100, one-cycle read latency.
  always @(posedge clock) begin
    fif.imem_q <= 32'(fif.imem_addr) + 32'd100;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs and push what F/D must look like after the edge.
  task automatic applyStimulus(input string tag, input logic stall_in,
                               input logic redirect_in, input logic [31:0] rpc,
                               input logic exp_valid, input logic [31:0] exp_insn,
                               input logic [31:0] exp_fd_pc, input logic [31:0] exp_pc);
    exp_t e;
    fif.stall       = stall_in;
    fif.redirect    = redirect_in;
    fif.redirect_pc = rpc;
    #1;
    checkOutput({tag, ".flush_dx"}, 32'(fif.flush_dx), 32'(redirect_in));
    e.tag   = tag;
    e.valid = exp_valid;
    e.insn  = exp_insn;
    e.fd_pc = exp_fd_pc;
    e.pc    = exp_pc;
    sb_queue.push_back(e);
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Scoreboard: compare the oldest expectation against the settled outputs.
  always @(negedge clock) begin
    if (sb_queue.size() > 0) begin
      exp_t e;
      logic [31:0] exp_p4;
      e = sb_queue.pop_front();
      exp_p4 = e.fd_pc + 32'd1;
      checkOutput({e.tag, ".fd_valid"}, 32'(fif.fd_valid), 32'(e.valid));
      checkOutput({e.tag, ".fd_insn"}, fif.fd_insn, e.insn);
      checkOutput({e.tag, ".pc_out"}, fif.pc_out, e.pc);
      checkOutput({e.tag, ".imem_addr"}, 32'(fif.imem_addr), 32'(e.pc[ADDR_W-1:0]));
      if (e.valid) begin
        checkOutput({e.tag, ".fd_pc_plus_4"}, fif.fd_pc_plus_4, exp_p4);
        checkOutput({e.tag, ".fd_pc_upper_5"}, 32'(fif.fd_pc_upper_5), 32'(e.fd_pc[31:27]));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assert_count    = 0;
    fail_count      = 0;
    reset           = 1'b1;
    fif.stall       = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 32'd0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;

    // Reset values.
    checkOutput("rst.fd_valid", 32'(fif.fd_valid), 32'd0);
    checkOutput("rst.fd_insn", fif.fd_insn, 32'd0);
    checkOutput("rst.fd_pc_plus_4", fif.fd_pc_plus_4, 32'd1);
    checkOutput("rst.fd_pc_upper_5", 32'(fif.fd_pc_upper_5), 32'd0);
    checkOutput("rst.pc_out", fif.pc_out, 32'd0);
    checkOutput("rst.imem_addr", 32'(fif.imem_addr), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("first.fd_valid", 32'(fif.fd_valid), 32'd0);

    // Straight-line fetch from address 0.
    for (int k = 0; k < 3; k++) begin
      applyStimulus("seq", 1'b0, 1'b0, 32'd0, 1'b1, 32'(k) + 32'd100, 32'(k), 32'(k) + 32'd1);
    end

    // Three-cycle stall on insn 102, then 103..105 with no duplicate or skip.
    for (int k = 0; k < 3; k++) begin
      applyStimulus("stall", 1'b1, 1'b0, 32'd0, 1'b1, 32'd102, 32'd2, 32'd3);
    end
    for (int k = 3; k < 6; k++) begin
      applyStimulus("release", 1'b0, 1'b0, 32'd0, 1'b1, 32'(k) + 32'd100, 32'(k), 32'(k) + 32'd1);
    end

    // Redirect to 40 while 105 sits in F/D.
    applyStimulus("redir", 1'b0, 1'b1, 32'd40, 1'b0, 32'd0, 32'd5, 32'd40);
    applyStimulus("redir_tgt", 1'b0, 1'b0, 32'd0, 1'b1, 32'd140, 32'd40, 32'd41);
    applyStimulus("redir_next", 1'b0, 1'b0, 32'd0, 1'b1, 32'd141, 32'd41, 32'd42);

    // Redirect and stall together while HELD.
    applyStimulus("held", 1'b1, 1'b0, 32'd0, 1'b1, 32'd141, 32'd41, 32'd42);
    applyStimulus("held_redir", 1'b1, 1'b1, 32'd200, 1'b0, 32'd0, 32'd41, 32'd200);
    applyStimulus("held_tgt", 1'b0, 1'b0, 32'd0, 1'b1, 32'd300, 32'd200, 32'd201);

    // Redirect to the top of the address space and wrap.
    applyStimulus("wrap_redir", 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd200, 32'hFFFF_FFFF);
    applyStimulus("wrap_tgt", 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0FFF + 32'd100, 32'hFFFF_FFFF, 32'd0);
    applyStimulus("wrap_next", 1'b0, 1'b0, 32'd0, 1'b1, 32'd100, 32'd0, 32'd1);

    // Stall during a bubble keeps it a bubble.
    applyStimulus("bub_redir", 1'b0, 1'b1, 32'd10, 1'b0, 32'd0, 32'd0, 32'd10);
    applyStimulus("bub_stall", 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd10);
    applyStimulus("bub_go", 1'b0, 1'b0, 32'd0, 1'b1, 32'd110, 32'd10, 32'd11);
    applyStimulus("pre_held", 1'b0, 1'b0, 32'd0, 1'b1, 32'd111, 32'd11, 32'd12);
    applyStimulus("held2", 1'b1, 1'b0, 32'd0, 1'b1, 32'd111, 32'd11, 32'd12);

    // Asynchronous reset mid-cycle while HELD; outputs must clear before the edge.
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async.pc_out", fif.pc_out, 32'd0);
    checkOutput("async.fd_valid", 32'(fif.fd_valid), 32'd0);
    checkOutput("async.fd_insn", fif.fd_insn, 32'd0);
    checkOutput("async.fd_pc_plus_4", fif.fd_pc_plus_4, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    #1;
    applyStimulus("post_rst", 1'b0, 1'b0, 32'd0, 1'b1, 32'd100, 32'd0, 32'd1);
    applyStimulus("post_rst2", 1'b0, 1'b0, 32'd0, 1'b1, 32'd101, 32'd1, 32'd2);

    checkOutput("sb_drain", 32'(sb_queue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule : tb_stage_fetch
